// File: rtl/hop_key_conditioner.sv
// hop_key_conditioner: synchronises and debounces two hop keys into one-cycle hop pulses.
// Optional auto-repeat while a key is held is enabled by defining HOP_REPEAT_EN.
module hop_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic key_fwd_n,
  input  logic key_back_n,
  output logic hop_fwd,
  output logic hop_back,
  output logic key_busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, FWD_HELD, BACK_HELD, LOCKOUT} state_t;
  state_t state_q, state_d;
  logic [1:0] s1_q, s2_q, stable_q, stable_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic fwd_q, back_q, fwd_d, back_d, fp, bp, rpt_fire;
  // bit 0 is the forward key, bit 1 the backward key
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = '0;
      if (s2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == DB_LAST) stable_d[k] = ~stable_q[k];
        else cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end
  assign fp = ~stable_q[0];
  assign bp = ~stable_q[1];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = (fp && bp) ? LOCKOUT : fp ? FWD_HELD : bp ? BACK_HELD : IDLE;
      FWD_HELD:  state_d = bp ? LOCKOUT : fp ? FWD_HELD : IDLE;
      BACK_HELD: state_d = fp ? LOCKOUT : bp ? BACK_HELD : IDLE;
      default:   state_d = (fp || bp) ? LOCKOUT : IDLE;
    endcase
  end
  assign fwd_d  = (state_q == IDLE && state_d == FWD_HELD) || (rpt_fire && state_q == FWD_HELD);
  assign back_d = (state_q == IDLE && state_d == BACK_HELD) || (rpt_fire && state_q == BACK_HELD);
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_q     <= '1;
      s2_q     <= '1;
      stable_q <= '1;
      cnt_q    <= '{default: '0};
      state_q  <= IDLE;
      fwd_q    <= 1'b0;
      back_q   <= 1'b0;
    end else begin
      s1_q     <= {key_back_n, key_fwd_n};
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      fwd_q    <= fwd_d;
      back_q   <= back_d;
    end
  end
`ifdef HOP_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_q;
  logic held;
  // counts only while staying in a held state, so entry and exit both restart it
  assign held     = (state_q == FWD_HELD || state_q == BACK_HELD) && state_d == state_q;
  assign rpt_fire = held && rpt_q == RPT_LAST;
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) rpt_q <= '0;
    else rpt_q <= (held && !rpt_fire) ? rpt_q + 1'b1 : '0;
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
  assign rpt_fire = 1'b0;
`endif
  assign hop_fwd  = fwd_q;
  assign hop_back = back_q;
  assign key_busy = state_q != IDLE;
endmodule

// File: tb/tb_hop_key_conditioner.sv
// tb_hop_key_conditioner: directed and randomized checks of hop_key_conditioner against a
// behavioural model (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10).
module tb_hop_key_conditioner;
  localparam int D = 4;
  localparam int R = 10;
  logic clk = 1'b0, rst_n = 1'b0, kf = 1'b1, kb = 1'b1;
  logic hf, hb, busy;
  int checks = 0, failures = 0;
  hop_key_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .CLOCK_50(clk), .resetn(rst_n), .key_fwd_n(kf), .key_back_n(kb),
    .hop_fwd(hf), .hop_back(hb), .key_busy(busy)
  );
  always #5 clk = ~clk;
  // model: sampled key history, accepted levels, and a hold-mode (0 idle,1 fwd,2 back,3 lockout)
  bit [1:0] m1, m2, mst;
  bit [1:0] hist[$];
  int mode, cyc, entry;
  bit ef, eb;
  int tcount, npf, npb, first_f, first_b;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic mreset();
    m1 = 2'b11; m2 = 2'b11; mst = 2'b11;
    hist = {};
    for (int i = 0; i < D; i++) hist.push_back(2'b11);
    mode = 0; ef = 0; eb = 0; entry = 0;
  endtask
  task automatic mstep();
    bit fpm, bpm, all_diff;
    int nx;
    cyc++;
    fpm = !mst[0]; bpm = !mst[1];
    if (mode == 0) nx = (fpm && bpm) ? 3 : fpm ? 1 : bpm ? 2 : 0;
    else if (mode == 1) nx = bpm ? 3 : fpm ? 1 : 0;
    else if (mode == 2) nx = fpm ? 3 : bpm ? 2 : 0;
    else nx = (fpm || bpm) ? 3 : 0;
    ef = (mode == 0 && nx == 1);
    eb = (mode == 0 && nx == 2);
`ifdef HOP_REPEAT_EN
    if ((mode == 1 || mode == 2) && nx == mode && (cyc - entry) % R == 0) begin
      ef |= (mode == 1);
      eb |= (mode == 2);
    end
`endif
    if (mode == 0 && (nx == 1 || nx == 2)) entry = cyc;
    hist.push_back(m2);
    void'(hist.pop_front());
    for (int k = 0; k < 2; k++) begin
      all_diff = 1;
      foreach (hist[j]) if (hist[j][k] == mst[k]) all_diff = 0;
      if (all_diff) mst[k] = !mst[k];
    end
    m2 = m1;
    m1 = {kb, kf};
    mode = nx;
  endtask
  task automatic mark();
    tcount = 0; npf = 0; npb = 0; first_f = -1; first_b = -1;
  endtask
  task automatic tick();
    @(posedge clk);
    mstep();
    @(negedge clk);
    tcount++;
    if (hf) begin npf++; if (first_f < 0) first_f = tcount; end
    if (hb) begin npb++; if (first_b < 0) first_b = tcount; end
    chk("hop_fwd", int'(hf), int'(ef));
    chk("hop_back", int'(hb), int'(eb));
    chk("key_busy", int'(busy), int'(mode != 0));
    chk("pulse_excl", int'(hf & hb), 0);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_hop_fwd", int'(hf), 0);
    chk("rst_hop_back", int'(hb), 0);
    chk("rst_busy", int'(busy), 0);
    mreset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    cyc = 0;
    mreset();
    do_reset();
    // clean forward press: single pulse after 7 cycles, busy until release settles
    mark(); kf = 0; ticks(20);
    chk("fwd_latency", first_f, 7);
    chk("fwd_count", npf, 1);
    chk("fwd_busy_held", int'(busy), 1);
    kf = 1; ticks(10);
    chk("fwd_release_idle", int'(busy), 0);
    // short bounce on back key
    mark(); kb = 0; ticks(3); kb = 1; ticks(10);
    chk("bounce_back_count", npb, 0);
    chk("bounce_busy", int'(busy), 0);
    // both keys together
    mark(); kf = 0; kb = 0; ticks(10);
    chk("both_lockout_busy", int'(busy), 1);
    kf = 1; kb = 1; ticks(6);
    chk("both_still_busy", int'(busy), 1);
    ticks(1);
    chk("both_idle_after7", int'(busy), 0);
    chk("both_pulses", npf + npb, 0);
    // forward then back 5 cycles later
    mark(); kf = 0; ticks(5); kb = 0; ticks(15);
    kf = 1; ticks(10);
    chk("fb_lock_one_released", int'(busy), 1);
    kb = 1; ticks(10);
    chk("fb_fwd_count", npf, 1);
    chk("fb_back_count", npb, 0);
    chk("fb_idle", int'(busy), 0);
    // reset while held
    kf = 0; ticks(10);
    do_reset();
    mark(); ticks(12);
    chk("rst_reholds_latency", first_f, 7);
    kf = 1; ticks(10);
    // long hold: repeat behaviour
    mark(); kf = 0; ticks(40);
`ifdef HOP_REPEAT_EN
    chk("hold40_count", npf, 4);
`else
    chk("hold40_count", npf, 1);
`endif
    chk("hold40_first", first_f, 7);
    kf = 1; ticks(10);
    // randomized key activity with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) kf = ~kf;
      if ($urandom_range(0, 7) == 0) kb = ~kb;
      if ($urandom_range(0, 599) == 0) do_reset();
      tick();
    end
    kf = 1; kb = 1; ticks(12);
    chk("final_idle", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
